// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single synchronous-read memory
// Define ARB_RR_EN for round-robin contention; default build is fixed priority with D winning.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_we,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   wr_q, wr_d;
`ifdef ARB_RR_EN
    logic   last_d_q, last_d_d;
`endif

    // Grants are purely combinational so a lone requester is served the cycle it asks.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (i_req && d_req) begin
`ifdef ARB_RR_EN
                if (last_d_q) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
`else
                d_gnt = 1'b1;
`endif
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_we    = 4'h0;
        if (d_gnt) begin
            m_en    = 1'b1;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_we    = d_we;
        end else if (i_gnt) begin
            m_en    = 1'b1;
            m_addr  = i_addr;
        end
    end

    always_comb begin
        state_d = IDLE;
        wr_d    = wr_q;
`ifdef ARB_RR_EN
        last_d_d = last_d_q;
`endif
        if (!reset) begin
            state_d = IDLE;
            wr_d    = 1'b0;
`ifdef ARB_RR_EN
            last_d_d = 1'b0;
`endif
        end else if (d_gnt) begin
            state_d = RESP_D;
            wr_d    = |d_we;
`ifdef ARB_RR_EN
            last_d_d = 1'b1;
`endif
        end else if (i_gnt) begin
            state_d = RESP_I;
`ifdef ARB_RR_EN
            last_d_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        wr_q    <= wr_d;
`ifdef ARB_RR_EN
        last_d_q <= last_d_d;
`endif
    end

    // Responses are masked during reset so a grant issued just before reset never answers.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'h0;
        d_rvalid = 1'b0;
        d_rdata  = 32'h0;
        if (reset) begin
            if (state_q == RESP_I) begin
                i_rvalid = 1'b1;
                i_rdata  = m_rdata;
            end
            if (state_q == RESP_D) begin
                d_rvalid = 1'b1;
                d_rdata  = wr_q ? 32'h0 : m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_we;
    logic        m_en;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_we;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
    );

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: who owns the response next cycle (0 none, 1 fetch, 2 data), and who won last.
    int exp_g;
    int resp_port  = 0;
    bit resp_wr    = 1'b0;
    bit last_was_d = 1'b0;

    logic        obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid;
    logic [31:0] obs_i_rdata, obs_d_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int pick_winner();
        if (!reset) return 0;
        if (i_req && d_req) return (RR && last_was_d) ? 1 : 2;
        if (d_req) return 2;
        if (i_req) return 1;
        return 0;
    endfunction

    task automatic cycle();
        logic [31:0] ea, ew;
        logic [3:0]  ewe;
        bit          ir, dr;
        @(negedge clk);
        exp_g = pick_winner();
        ea  = (exp_g == 1) ? i_addr : (exp_g == 2) ? d_addr : 32'h0;
        ew  = (exp_g == 2) ? d_wdata : 32'h0;
        ewe = (exp_g == 2) ? d_we : 4'h0;
        ir  = reset && (resp_port == 1);
        dr  = reset && (resp_port == 2);
        check_eq("i_gnt", i_gnt, exp_g == 1);
        check_eq("d_gnt", d_gnt, exp_g == 2);
        check_eq("m_en", m_en, exp_g != 0);
        check_eq("m_addr", m_addr, ea);
        check_eq("m_wdata", m_wdata, ew);
        check_eq("m_we", m_we, ewe);
        check_eq("i_rvalid", i_rvalid, ir);
        check_eq("i_rdata", i_rdata, ir ? m_rdata : 32'h0);
        check_eq("d_rvalid", d_rvalid, dr);
        check_eq("d_rdata", d_rdata, (dr && !resp_wr) ? m_rdata : 32'h0);
        obs_i_gnt = i_gnt;       obs_d_gnt = d_gnt;
        obs_i_rvalid = i_rvalid; obs_d_rvalid = d_rvalid;
        obs_i_rdata = i_rdata;   obs_d_rdata = d_rdata;
        @(posedge clk);
        #1;
        if (!reset) begin
            resp_port  = 0;
            resp_wr    = 1'b0;
            last_was_d = 1'b0;
        end else begin
            resp_port = exp_g;
            if (exp_g == 2) resp_wr = (d_we != 4'h0);
            if (exp_g != 0) last_was_d = (exp_g == 2);
        end
        if (exp_g == 1) i_req = 1'b0;
        if (exp_g == 2) d_req = 1'b0;
        m_rdata = $urandom;
    endtask

    initial begin
        logic [3:0] seq;
        int         irv;
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1;
        i_addr = 32'h100; d_addr = 32'h200; d_wdata = 32'h0; d_we = 4'h0;
        m_rdata = 32'h0;

        // Reset held with both requesting, then first contention goes to D.
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check_eq("first_contention_d", obs_d_gnt, 1'b1);
        cycle();
        check_eq("pending_i_served", obs_i_gnt, 1'b1);
        i_req = 1'b0; d_req = 1'b0;
        cycle();

        // Lone fetch.
        i_req = 1'b1; i_addr = 32'h10;
        cycle();
        m_rdata = 32'hDEADBEEF;
        cycle();
        check_eq("fetch_rvalid", obs_i_rvalid, 1'b1);
        check_eq("fetch_rdata", obs_i_rdata, 32'hDEADBEEF);
        check_eq("fetch_no_d_rvalid", obs_d_rvalid, 1'b0);

        // Data write.
        d_req = 1'b1; d_addr = 32'h24; d_we = 4'b1100; d_wdata = 32'hABCD0000;
        cycle();
        cycle();
        check_eq("write_ack", obs_d_rvalid, 1'b1);
        check_eq("write_rdata", obs_d_rdata, 32'h0);

        // Sustained contention from a fresh reset.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        seq = 4'h0; irv = 0;
        d_we = 4'h0;
        for (int k = 0; k < 4; k++) begin
            i_req = 1'b1; d_req = 1'b1;
            cycle();
            seq = {seq[2:0], obs_d_gnt};
            irv += int'(obs_i_rvalid);
        end
        check_eq("contention_seq", {28'h0, seq}, RR ? 32'hA : 32'hF);
        check_eq("contention_i_rvalid", irv, RR ? 32'd1 : 32'd0);
        i_req = 1'b0; d_req = 1'b0;
        cycle();
        cycle();

        // D read then I fetch back to back.
        d_req = 1'b1; d_addr = 32'h40; d_we = 4'h0;
        cycle();
        i_req = 1'b1; i_addr = 32'h44;
        cycle();
        check_eq("b2b_d_rvalid", obs_d_rvalid, 1'b1);
        check_eq("b2b_i_gnt", obs_i_gnt, 1'b1);
        cycle();
        check_eq("b2b_i_rvalid", obs_i_rvalid, 1'b1);

        // Grant then immediate reset drops the response.
        i_req = 1'b1; i_addr = 32'h80;
        cycle();
        reset = 1'b0;
        cycle();
        check_eq("rst_drop_resp", obs_i_rvalid, 1'b0);
        reset = 1'b1;
        cycle();
        check_eq("rst_drop_after", obs_i_rvalid, 1'b0);

        // Random traffic with occasional reset.
        for (int n = 0; n < 2000; n++) begin
            if (!i_req && ($urandom % 3 == 0)) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (!d_req && ($urandom % 3 == 0)) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                d_we = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            end
            reset = ($urandom % 40 != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
